// File: rtl/udp_gmii_rx.sv
// udp_gmii_rx: GMII receive path. It strips the preamble/SFD, filters the Ethernet/IPv4/UDP headers,
// streams the UDP payload and reports per-frame status. Define UDP_GMII_RX_CRC_EN to enable the FCS check.
module udp_gmii_rx #(
  parameter logic [47:0] P_MAC      = 48'h00_0A_35_01_02_03,
  parameter logic [15:0] P_UDP_PORT = 16'd5000,
  parameter logic [10:0] P_MAX_PAY  = 11'd1472
) (
  input  logic        RCLK,
  input  logic        ARST,
  input  logic [7:0]  RXD,
  input  logic        RXDV,
  input  logic        RXER,
  output logic [7:0]  RX_DATA,
  output logic        RX_VALID,
  output logic        RX_LAST,
  output logic [15:0] RX_SRC_PORT,
  output logic        STAT_VALID,
  output logic        STAT_OK,
  output logic        DROP
);

  localparam int unsigned IDX_W = 6;
  localparam int unsigned CNT_W = 11;

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_HDR, S_PAY, S_TAIL, S_STAT, S_DROPW
  } state_t;

  state_t           state;
  logic [7:0]       rxd_q;
  logic             rxdv_q;
  logic             rxer_q;
  logic [IDX_W-1:0] k;
  logic             uc_ok;
  logic             bc_ok;
  logic [15:0]      src_port;
  logic [15:0]      udp_len;
  logic [CNT_W-1:0] cnt;
  logic             err;

  logic [7:0]  mac_byte_c;
  logic        uc_next_c;
  logic        bc_next_c;
  logic        hdr_bad_c;
  logic [15:0] pay_len_c;
  logic        len_bad_c;
  logic        crc_ok_c;

  // Per-byte header check against the expected field values
  always_comb begin
    mac_byte_c = 8'h00;
    case (k)
      6'd0:    mac_byte_c = P_MAC[47:40];
      6'd1:    mac_byte_c = P_MAC[39:32];
      6'd2:    mac_byte_c = P_MAC[31:24];
      6'd3:    mac_byte_c = P_MAC[23:16];
      6'd4:    mac_byte_c = P_MAC[15:8];
      6'd5:    mac_byte_c = P_MAC[7:0];
      default: mac_byte_c = 8'h00;
    endcase
    uc_next_c = uc_ok & (rxd_q == mac_byte_c);
    bc_next_c = bc_ok & (rxd_q == 8'hFF);
    hdr_bad_c = 1'b0;
    if (k < 6'd6) begin
      hdr_bad_c = ~(uc_next_c | bc_next_c);
    end else begin
      case (k)
        6'd12:   hdr_bad_c = (rxd_q != 8'h08);
        6'd13:   hdr_bad_c = (rxd_q != 8'h00);
        6'd14:   hdr_bad_c = (rxd_q != 8'h45);
        6'd23:   hdr_bad_c = (rxd_q != 8'h11);
        6'd36:   hdr_bad_c = (rxd_q != P_UDP_PORT[15:8]);
        6'd37:   hdr_bad_c = (rxd_q != P_UDP_PORT[7:0]);
        default: hdr_bad_c = 1'b0;
      endcase
    end
    pay_len_c = udp_len - 16'd8;
    len_bad_c = (udp_len < 16'd8) || (pay_len_c > 16'(P_MAX_PAY));
  end

`ifdef UDP_GMII_RX_CRC_EN
  logic [31:0] crc;

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    end
    return r;
  endfunction

  // Restarted throughout the preamble so k=0 always starts from the all-ones seed
  always_ff @(posedge RCLK or posedge ARST) begin
    if (ARST) begin
      crc <= 32'hFFFF_FFFF;
    end else if (state == S_PRE) begin
      crc <= 32'hFFFF_FFFF;
    end else if (rxdv_q && (state == S_HDR || state == S_PAY || state == S_TAIL)) begin
      crc <= crc_step(crc, rxd_q);
    end
  end

  assign crc_ok_c = (crc == 32'hDEBB_20E3);
`else
  assign crc_ok_c = 1'b1;
`endif

  always_ff @(posedge RCLK or posedge ARST) begin
    if (ARST) begin
      state       <= S_IDLE;
      rxd_q       <= 8'h00;
      rxdv_q      <= 1'b0;
      rxer_q      <= 1'b0;
      k           <= '0;
      uc_ok       <= 1'b0;
      bc_ok       <= 1'b0;
      src_port    <= 16'h0000;
      udp_len     <= 16'h0000;
      cnt         <= '0;
      err         <= 1'b0;
      RX_DATA     <= 8'h00;
      RX_VALID    <= 1'b0;
      RX_LAST     <= 1'b0;
      RX_SRC_PORT <= 16'h0000;
      STAT_VALID  <= 1'b0;
      STAT_OK     <= 1'b0;
      DROP        <= 1'b0;
    end else begin
      rxd_q      <= RXD;
      rxdv_q     <= RXDV;
      rxer_q     <= RXER;
      RX_VALID   <= 1'b0;
      RX_LAST    <= 1'b0;
      STAT_VALID <= 1'b0;
      STAT_OK    <= 1'b0;
      DROP       <= 1'b0;
      case (state)
        // STAT behaves like IDLE so a one-cycle inter-frame gap still catches the next preamble
        S_IDLE, S_STAT: begin
          if (rxdv_q) begin
            if (rxd_q == 8'h55) begin
              state <= S_PRE;
            end else begin
              state <= S_DROPW;
              DROP  <= 1'b1;
            end
          end else begin
            state <= S_IDLE;
          end
        end
        S_PRE: begin
          if (!rxdv_q) begin
            state <= S_DROPW;
            DROP  <= 1'b1;
          end else if (rxd_q == 8'hD5) begin
            state <= S_HDR;
            k     <= '0;
            uc_ok <= 1'b1;
            bc_ok <= 1'b1;
            err   <= 1'b0;
          end else if (rxd_q != 8'h55) begin
            state <= S_DROPW;
            DROP  <= 1'b1;
          end
        end
        S_HDR: begin
          if (!rxdv_q || hdr_bad_c) begin
            state <= S_DROPW;
            DROP  <= 1'b1;
          end else begin
            err <= err | rxer_q;
            k   <= k + 6'd1;
            if (k < 6'd6) begin
              uc_ok <= uc_next_c;
              bc_ok <= bc_next_c;
            end
            case (k)
              6'd34:   src_port[15:8] <= rxd_q;
              6'd35:   src_port[7:0]  <= rxd_q;
              6'd38:   udp_len[15:8]  <= rxd_q;
              6'd39:   udp_len[7:0]   <= rxd_q;
              default: ;
            endcase
            if (k == 6'd41) begin
              if (len_bad_c) begin
                state <= S_DROPW;
                DROP  <= 1'b1;
              end else begin
                RX_SRC_PORT <= src_port;
                cnt         <= CNT_W'(pay_len_c);
                state       <= (pay_len_c == 16'd0) ? S_TAIL : S_PAY;
              end
            end
          end
        end
        // Payload stream; an early RXDV drop ends the frame incomplete
        S_PAY: begin
          if (!rxdv_q) begin
            state      <= S_STAT;
            STAT_VALID <= 1'b1;
            STAT_OK    <= 1'b0;
          end else begin
            RX_VALID <= 1'b1;
            RX_DATA  <= rxd_q;
            err      <= err | rxer_q;
            cnt      <= cnt - 11'd1;
            if (cnt == 11'd1) begin
              RX_LAST <= 1'b1;
              state   <= S_TAIL;
            end
          end
        end
        S_TAIL: begin
          if (!rxdv_q) begin
            state      <= S_STAT;
            STAT_VALID <= 1'b1;
            STAT_OK    <= crc_ok_c & ~err;
          end else begin
            err <= err | rxer_q;
          end
        end
        S_DROPW: begin
          if (!rxdv_q) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
